// File: rtl/mux_lane_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux lane arbiter.
// The optional hold-limit rotation is enabled with MUX_LANE_ARB_TIMEOUT_EN.
package mux_lane_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned HOLD_CNT_W = 8;
  localparam int unsigned MAX_N      = 32;

  // First set bit of req at or after start, wrapping at n (start < n <= MAX_N).
  function automatic logic [4:0] next_rr(input logic [MAX_N-1:0] req,
                                         input logic [4:0]       start,
                                         input int unsigned      n);
    logic [4:0]  res;
    logic        found;
    int unsigned idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        idx = 32'(start) + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[4:0]]) begin
          res   = idx[4:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_lane_arbiter_if.sv
// Requester/lane bundle between fabric user logic and the shared mux lane arbiter.
interface mux_lane_arbiter_if #(
  parameter int N = 32
);
  localparam int SEL_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     data_in;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;
  logic             o;
  logic             o_valid;
  logic             busy;

  modport master (
    output req, data_in,
    input  grant, sel, o, o_valid, busy
  );

  modport slave (
    input  req, data_in,
    output grant, sel, o, o_valid, busy
  );
endinterface

// File: rtl/mux_lane_arbiter_sel.sv
// Parameterised N:1 bit select modelling the shared wide-mux lane.
module mux_lane_sel #(
  parameter int N     = 32,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     data_in,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);
  always_comb begin
    y = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) y = data_in[i];
    end
  end
endmodule

// File: rtl/mux_lane_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 lane, with a registered output.
// Define MUX_LANE_ARB_TIMEOUT_EN to force rotation after HOLD_MAX grant cycles.
module mux_lane_arbiter
  import mux_lane_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int HOLD_MAX = 16
) (
  input logic               CLK,
  input logic               RST,
  mux_lane_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(N);

  if (N < 2 || N > int'(MAX_N) || HOLD_MAX < 1 || HOLD_MAX > (1 << HOLD_CNT_W) - 1) begin : g_bad_cfg
    $error("mux_lane_arbiter: illegal N or HOLD_MAX");
  end

  state_t           state, state_n;
  logic [N-1:0]     grant, grant_n;
  logic [SEL_W-1:0] sel, sel_n, ptr, ptr_n;
  logic [SEL_W-1:0] owner_inc, start, pick;
  logic [MAX_N-1:0] pend;
  logic             owner_req, new_grant, rotate_timeout;
  logic             mux_bit, o_r, o_valid_r;

  assign owner_inc = (sel == SEL_W'(N - 1)) ? '0 : sel + 1'b1;
  assign owner_req = |(bus.req & grant);

`ifdef MUX_LANE_ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);
  logic [HOLD_CNT_W-1:0] hold_cnt;

  assign rotate_timeout = (hold_cnt == HOLD_LAST);

  // Saturates at the limit so a late competitor rotates on its first pending edge.
  always_ff @(posedge CLK) begin
    if (RST)                                         hold_cnt <= '0;
    else if (new_grant)                              hold_cnt <= '0;
    else if (state == GRANT && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign rotate_timeout = 1'b0;
`endif

  // In GRANT the owner is masked out, so one search serves release and timeout.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    sel_n     = sel;
    ptr_n     = ptr;
    new_grant = 1'b0;
    pend      = '0;
    pend[N-1:0] = (state == GRANT) ? (bus.req & ~grant) : bus.req;
    start     = (state == GRANT) ? owner_inc : ptr;
    pick      = SEL_W'(next_rr(pend, 5'(start), N));
    case (state)
      IDLE: begin
        if (|pend) begin
          state_n   = GRANT;
          sel_n     = pick;
          grant_n   = N'(1) << pick;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req || rotate_timeout) begin
          if (|pend) begin
            sel_n     = pick;
            grant_n   = N'(1) << pick;
            ptr_n     = owner_inc;
            new_grant = 1'b1;
          end else if (!owner_req) begin
            state_n = IDLE;
            grant_n = '0;
            ptr_n   = owner_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      ptr       <= '0;
      o_r       <= 1'b0;
      o_valid_r <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      sel       <= sel_n;
      ptr       <= ptr_n;
      o_r       <= (state == GRANT) ? mux_bit : 1'b0;
      o_valid_r <= (state == GRANT);
    end
  end

  mux_lane_sel #(.N(N), .SEL_W(SEL_W)) u_sel (
    .data_in (bus.data_in),
    .sel     (sel),
    .y       (mux_bit)
  );

  assign bus.grant   = grant;
  assign bus.sel     = sel;
  assign bus.o       = o_r;
  assign bus.o_valid = o_valid_r;
  assign bus.busy    = (state == GRANT);

endmodule

// File: tb/tb_mux_lane_arbiter.sv
// Scoreboard bench for mux_lane_arbiter: a 32-lane and a 5-lane instance against a behavioural model.
module tb_mux_lane_arbiter;
  localparam int NA     = 32;
  localparam int NB     = 5;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 16;
`ifdef MUX_LANE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  mux_lane_arbiter_if #(.N(NA)) bus_a ();
  mux_lane_arbiter_if #(.N(NB)) bus_b ();

  mux_lane_arbiter #(.N(NA), .HOLD_MAX(HOLD_A)) dut_a (.CLK(clk), .RST(rst_a), .bus(bus_a));
  mux_lane_arbiter #(.N(NB), .HOLD_MAX(HOLD_B)) dut_b (.CLK(clk), .RST(rst_b), .bus(bus_b));

  typedef struct {
    int          u;
    logic [39:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit          m_busy[2];
  int unsigned m_own[2], m_ptr[2], m_hold[2];
  logic        m_o[2], m_ov[2];

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned search(input logic [31:0] r, input int unsigned start,
                                         input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      if (r[(start + k) % n]) return (start + k) % n;
    return start;
  endfunction

  task automatic model_step(input int u, input int unsigned n, input int unsigned hmax,
                            input logic rst, input logic [31:0] r, input logic [31:0] d);
    exp_t        e;
    logic        new_o, new_ov, expired;
    logic [31:0] others;
    int unsigned nxt;
    if (rst) begin
      m_busy[u] = 1'b0; m_own[u] = 0; m_ptr[u] = 0; m_hold[u] = 0;
      m_o[u] = 1'b0; m_ov[u] = 1'b0;
    end else begin
      new_o  = m_busy[u] ? d[m_own[u]] : 1'b0;
      new_ov = m_busy[u];
      if (!m_busy[u]) begin
        if (r != 0) begin
          m_own[u] = search(r, m_ptr[u], n); m_busy[u] = 1'b1; m_hold[u] = 0;
        end
      end else begin
        others = r;
        others[m_own[u]] = 1'b0;
        expired = TO_EN && (m_hold[u] == hmax - 1);
        nxt = (m_own[u] + 1) % n;
        if ((!r[m_own[u]] || expired) && others != 0) begin
          m_own[u] = search(others, nxt, n); m_ptr[u] = nxt; m_hold[u] = 0;
        end else if (!r[m_own[u]]) begin
          m_ptr[u] = nxt; m_busy[u] = 1'b0;
        end else if (m_hold[u] < hmax - 1) begin
          m_hold[u]++;
        end
      end
      m_o[u] = new_o; m_ov[u] = new_ov;
    end
    e.u = u;
    e.v = {(m_busy[u] ? (32'd1 << m_own[u]) : 32'd0), 5'(m_own[u]), m_o[u], m_ov[u], m_busy[u]};
    sb.push_back(e);
  endtask

  task automatic cycle(input logic ra, input logic [31:0] qa, input logic [31:0] da,
                       input logic rb, input logic [4:0] qb, input logic [4:0] db);
    exp_t        e;
    logic [39:0] act;
    @(negedge clk);
    rst_a = ra; bus_a.req = qa; bus_a.data_in = da;
    rst_b = rb; bus_b.req = qb; bus_b.data_in = db;
    model_step(0, NA, HOLD_A, ra, qa, da);
    model_step(1, NB, HOLD_B, rb, {27'd0, qb}, {27'd0, db});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.u == 0) act = {bus_a.grant, bus_a.sel, bus_a.o, bus_a.o_valid, bus_a.busy};
      else          act = {27'd0, bus_b.grant, 2'd0, bus_b.sel, bus_b.o, bus_b.o_valid, bus_b.busy};
      check(e.u == 0 ? "lane32" : "lane5", act, e.v);
    end
  endtask

  task automatic ca(input logic ra, input logic [31:0] qa);
    cycle(ra, qa, $urandom, 1'b0, 5'd0, 5'($urandom));
  endtask

  initial begin
    logic [4:0] qb;
    // reset with everything requesting
    repeat (2) cycle(1'b1, '1, $urandom, 1'b1, 5'h1f, 5'h1f);
    check("reset_outs", {bus_a.grant, bus_a.o, bus_a.o_valid, bus_a.busy}, '0);

    // single requester with data high
    cycle(1'b0, 32'h10, 32'h10, 1'b0, 5'd0, 5'd0);
    check("single_grant", {bus_a.grant, bus_a.sel}, {32'h10, 5'd4});
    cycle(1'b0, 32'h10, 32'h10, 1'b0, 5'd0, 5'd0);
    check("single_o", {bus_a.o, bus_a.o_valid}, 2'b11);
    ca(1'b0, 32'h0);
    ca(1'b0, 32'h0);
    check("single_drop", {bus_a.o_valid, bus_a.busy}, 2'b00);

    // fair rotation over 1, 5, 9
    ca(1'b1, 32'h0);
    ca(1'b0, 32'h222);
    check("rot_0", 40'(bus_a.sel), 40'd1);
    ca(1'b0, 32'h220);
    check("rot_1", 40'(bus_a.sel), 40'd5);
    ca(1'b0, 32'h202);
    check("rot_2", 40'(bus_a.sel), 40'd9);
    ca(1'b0, 32'h022);
    check("rot_3", {39'(bus_a.sel), bus_a.busy}, {39'd1, 1'b1});

    // hold limit: owner 2 keeps requesting while 7 waits
    ca(1'b1, 32'h0);
    ca(1'b0, 32'h4);
    repeat (4) ca(1'b0, 32'h84);
    check("timeout_owner", 40'(bus_a.sel), TO_EN ? 40'd7 : 40'd2);
    repeat (2) ca(1'b0, 32'h0);

    // a pulse between edges is never sampled
    bus_a.req = 32'h100;
    #2;
    bus_a.req = 32'h0;
    ca(1'b0, 32'h0);
    check("glitch_ignored", 40'(bus_a.busy), 40'd0);

    // mid-grant reset forgets the pointer
    ca(1'b1, 32'h0);
    ca(1'b0, 32'h200);
    ca(1'b0, 32'h0210_0000);
    check("pre_rst_owner", 40'(bus_a.sel), 40'd20);
    ca(1'b1, 32'h0200_0000);
    check("mid_rst", {bus_a.grant, bus_a.sel, bus_a.o, bus_a.o_valid, bus_a.busy}, '0);
    ca(1'b0, 32'h0200_0008);
    check("post_rst_search", 40'(bus_a.sel), 40'd3);
    ca(1'b0, 32'h0);

    // N=5 wrap: last grantee 3 leaves ptr at 4
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'b01000, 5'($urandom));
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'b00011, 5'($urandom));
    check("wrap_0", 40'(bus_b.sel), 40'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'b00010, 5'($urandom));
    check("wrap_1", 40'(bus_b.sel), 40'd1);

    // all five requesting, each releasing after one cycle
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 5'h0, 5'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'h1f, 5'($urandom));
    check("all_0", 40'(bus_b.sel), 40'd0);
    for (int i = 0; i < NB; i++) begin
      qb = 5'h1f & ~(5'd1 << i);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, qb, 5'($urandom));
      check("all_rot", 40'(bus_b.sel), 40'((i + 1) % NB));
    end
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'h0, 5'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux_lane_arbiter.md
Name: mux_lane_arbiter

Overview:
- Round-robin arbiter that shares one routing output lane between N requesters by driving the select of an N:1 configurable mux.
- Registers the mux output and flags when it is valid.
- Sits between fabric user logic and a shared wide-mux lane, e.g. a debug or readback lane built from the 32:1 mux primitive.
- A grant stays locked to its owner while the owner keeps requesting. It rotates fairly when the owner releases the lane, or optionally when a hold limit expires.

Parameters:
- N, 32, number of requesters and mux inputs; legal range 2..32, need not be a power of two.
- SEL_W, $clog2(N), width of the select bus; derived, not overridden.
- HOLD_MAX, 16, maximum consecutive grant cycles before a forced rotation; used only with the optional feature; legal range 1..255.

Ports:
- CLK  in  1  Clock; all state updates on the rising edge.
- RST  in  1  Synchronous, active-high reset.
- req  in  N  Per-requester request; level-sensitive.
- data_in  in  N  Per-requester data bit; these are the mux inputs.
- grant  out  N  One-hot grant; all zero when idle.
- sel  out  SEL_W  Binary index of the current grantee; drives the mux select.
- o  out  1  Registered mux output: data_in[sel] sampled one cycle after grant.
- o_valid  out  1  o carries the grantee's data.
- busy  out  1  High in the GRANT state.

Behaviour:
- Reset (RST high at a rising edge):
  - state=IDLE, grant=0, sel=0, ptr=0, o=0, o_valid=0, busy=0, hold_cnt=0.
  - A reset in the middle of a grant drops the grant immediately; no request is remembered.
- Priority pointer:
  - ptr is the index one past the last grantee, wrapping from N-1 to 0.
  - Search order is ptr, ptr+1, ..., wrapping at N.
- IDLE:
  - At an edge where req!=0, grant the first requester in search order.
  - At that edge: grant and sel load, busy=1, state moves to GRANT.
  - Latency: request sampled at edge k, grant visible after edge k.
- GRANT, owner g:
  - If req[g]=1, hold the grant (subject to the timeout below).
  - If req[g]=0 and another request is pending: grant the next requester in search order starting at g+1, at the same edge, with no idle bubble. ptr becomes g+1.
  - If req[g]=0 and nothing is pending: go to IDLE, grant=0, busy=0. sel keeps its last value. ptr becomes g+1.
- Output path:
  - At each edge, o <= (state==GRANT) ? data_in[sel] : 0.
  - At each edge, o_valid <= (state==GRANT).
  - o and o_valid therefore lag grant by one cycle.
  - On a handover, the cycle after the handover edge still shows the old owner's last bit; o_valid stays high across the handover.
- Invariants:
  - grant is one-hot or zero.
  - sel is always less than N.
  - grant[sel]=1 whenever busy=1.
- Boundary cases:
  - A request asserted and dropped between edges is never seen.
  - A single continuous requester holds the lane indefinitely (without the optional feature).
  - With all N requesting and each releasing after one cycle, grants go 0,1,...,N-1,0.

Optional Feature:
- Macro: MUX_LANE_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold_cnt clears on every new grant and increments each GRANT cycle.
  - When hold_cnt reaches HOLD_MAX-1 and another requester is pending, rotate at that edge to the next requester even though the owner's req is still 1. ptr becomes g+1.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates.
- Undefined:
  - No counter exists; grants are held until released.

Decomposition:
- Package mux_lane_arb_pkg:
  - State enum: IDLE and GRANT.
  - Function next_rr(req, start), returning the index of the first set bit at or after start, with wrap.
  - HOLD_CNT_W = 8.
- One sub-module, mux_lane_sel: a parameterised N:1 select (data_in, sel) to a combinational bit, feeding the o register.

Test Plan:
- Reset: drive RST for 2 cycles with req=all ones → grant=0, sel=0, o=0, o_valid=0, busy=0 throughout.
- Single request, N=32: req=0x0000_0010, data_in[4]=1 → after the first edge grant=0x10, sel=4; after the next edge o=1, o_valid=1. Drop req → IDLE, o_valid=0 one cycle later.
- Fair rotation: req bits 1, 5 and 9 held; the owner's req pulsed low for one cycle per turn → grant order 1,5,9,1 with no idle cycle between grants.
- Wrap with N=5: ptr=4, req=0b00011 → grant index 0 next, then 1.
- Timeout, macro defined, HOLD_MAX=4: req[2] held and req[7] raised → grant moves from 2 to 7 after 4 GRANT cycles. Same stimulus with the macro undefined → owner 2 is kept.
- Mid-grant reset: RST pulsed during GRANT with a handover pending → all outputs zero the next cycle. The next grant is found by searching from index 0.
